// File: rtl/fetch_pc_unit_pkg.sv
// Shared defaults and run-state encoding for the fetch program-counter unit.
package fetch_pc_unit_pkg;

    localparam int DEF_MWORD_SIZE       = 32;
    localparam int DEF_SMALL_NUMBER_SIZE = 8;
    localparam int DEF_ALIGN_BITS       = 2;
    localparam int DEF_FETCH_BLOCK_BITS = 4;
    localparam int DEF_TAG_BITS         = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pcState_t;

endpackage

// File: rtl/fetch_pc_next.sv
// Redirect address selection: picks the highest-priority redirect and forms its aligned address.
module fetch_pc_next
    import fetch_pc_unit_pkg::*;
#(
    parameter int MWORD_SIZE    = DEF_MWORD_SIZE,
    parameter int ALIGN_BITS    = DEF_ALIGN_BITS,
    parameter int INT_CODE_SIZE = DEF_SMALL_NUMBER_SIZE,
    parameter int EXC_CODE_SIZE = DEF_SMALL_NUMBER_SIZE
) (
    input  logic [MWORD_SIZE-1:0]    intBase,
    input  logic [MWORD_SIZE-1:0]    excBase,
    input  logic [MWORD_SIZE-1:0]    insTarget,
    input  logic [MWORD_SIZE-1:0]    insResult,
    input  logic [INT_CODE_SIZE-1:0] intCode,
    input  logic [EXC_CODE_SIZE-1:0] excCode,
    input  logic                     selectInt,
    input  logic                     selectExc,
    input  logic                     selectTarget,
    input  logic                     selectResult,
    output logic                     redirect,
    output logic                     trap,
    output logic [MWORD_SIZE-1:0]    nextPc
);

    always_comb begin
        redirect = selectInt | selectExc | selectTarget | selectResult;
        trap     = selectInt | selectExc;
        nextPc   = '0;
        // Handler entries replace the low base bits with the code, word-aligned.
        if (selectInt) begin
            nextPc = {intBase[MWORD_SIZE-1:INT_CODE_SIZE+ALIGN_BITS], intCode, {ALIGN_BITS{1'b0}}};
        end else if (selectExc) begin
            nextPc = {excBase[MWORD_SIZE-1:EXC_CODE_SIZE+ALIGN_BITS], excCode, {ALIGN_BITS{1'b0}}};
        end else if (selectTarget) begin
            nextPc = {insTarget[MWORD_SIZE-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
        end else if (selectResult) begin
            nextPc = {insResult[MWORD_SIZE-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch program counter: run control, block-wise advance, redirects with generation tags.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int MWORD_SIZE        = DEF_MWORD_SIZE,
    parameter int SMALL_NUMBER_SIZE = DEF_SMALL_NUMBER_SIZE,
    parameter int ALIGN_BITS        = DEF_ALIGN_BITS,
    parameter int FETCH_BLOCK_BITS  = DEF_FETCH_BLOCK_BITS,
    parameter int INT_CODE_SIZE     = SMALL_NUMBER_SIZE,
    parameter int EXC_CODE_SIZE     = SMALL_NUMBER_SIZE,
    parameter int TAG_BITS          = DEF_TAG_BITS,
    parameter logic [MWORD_SIZE-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [MWORD_SIZE-1:0]        INT_BASE,
    input  logic [MWORD_SIZE-1:0]        EXC_BASE,
    input  logic [MWORD_SIZE-1:0]        insTarget,
    input  logic [MWORD_SIZE-1:0]        insResult,
    input  logic [INT_CODE_SIZE-1:0]     intCode,
    input  logic [EXC_CODE_SIZE-1:0]     excCode,
    input  logic                         selectInt,
    input  logic                         selectExc,
    input  logic                         selectTarget,
    input  logic                         selectResult,
    input  logic                         start,
    input  logic                         halt,
    input  logic                         fetchReady,
    output logic [MWORD_SIZE-1:0]        pcOut,
    output logic                         pcValid,
    output logic [SMALL_NUMBER_SIZE-1:0] pcSize,
    output logic [TAG_BITS-1:0]          pcTag,
    output logic [MWORD_SIZE-1:0]        savedIP,
    output logic                         running,
    output pcState_t                     dbgState
);

    // Handshake: a block (pcOut, pcTag) transfers on a rising edge where
    // pcValid && fetchReady; pcValid never depends on fetchReady.

    localparam int BLK_W = MWORD_SIZE - FETCH_BLOCK_BITS;

    pcState_t                state, stateNext;
    logic                    redirect, trap;
    logic [MWORD_SIZE-1:0]   redirectPc;
    logic [BLK_W-1:0]        blockNext;
    logic [FETCH_BLOCK_BITS:0] remBytes;

    fetch_pc_next #(
        .MWORD_SIZE   (MWORD_SIZE),
        .ALIGN_BITS   (ALIGN_BITS),
        .INT_CODE_SIZE(INT_CODE_SIZE),
        .EXC_CODE_SIZE(EXC_CODE_SIZE)
    ) u_next (
        .intBase     (INT_BASE),
        .excBase     (EXC_BASE),
        .insTarget   (insTarget),
        .insResult   (insResult),
        .intCode     (intCode),
        .excCode     (excCode),
        .selectInt   (selectInt),
        .selectExc   (selectExc),
        .selectTarget(selectTarget),
        .selectResult(selectResult),
        .redirect    (redirect),
        .trap        (trap),
        .nextPc      (redirectPc)
    );

    always_comb begin
        stateNext = state;
        if (redirect) begin
            stateNext = RUN;
        end else if (halt) begin
            // halt wins over start; it only has an effect while running
            if (state == RUN) stateNext = HALTED;
        end else if (start) begin
            stateNext = RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    assign blockNext = pcOut[MWORD_SIZE-1:FETCH_BLOCK_BITS] + BLK_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcOut   <= RESET_PC;
            pcTag   <= '0;
            savedIP <= '0;
        end else if (redirect) begin
            pcOut <= redirectPc;
            pcTag <= pcTag + TAG_BITS'(1);
            if (trap) savedIP <= pcOut;
        end else if (state == RUN && fetchReady) begin
            pcOut <= {blockNext, {FETCH_BLOCK_BITS{1'b0}}};
        end
    end

    assign remBytes = {1'b1, {FETCH_BLOCK_BITS{1'b0}}} - {1'b0, pcOut[FETCH_BLOCK_BITS-1:0]};
    assign pcSize   = SMALL_NUMBER_SIZE'(remBytes >> ALIGN_BITS);
    assign pcValid  = (state == RUN);
    assign running  = (state == RUN);
    assign dbgState = state;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus random traffic against an arithmetic model.
module tb_fetch_pc_unit;
    import fetch_pc_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] INT_BASE, EXC_BASE, insTarget, insResult;
    logic [7:0]  intCode, excCode;
    logic        selectInt, selectExc, selectTarget, selectResult;
    logic        start, halt, fetchReady;
    logic [31:0] pcOut, savedIP;
    logic        pcValid, running;
    logic [7:0]  pcSize;
    logic [2:0]  pcTag;
    pcState_t    dbgState;

    int total = 0;
    int bad   = 0;

    // model: 0 idle, 1 run, 2 halted
    int          mMode;
    logic [31:0] mPc, mSaved;
    int          mTag;

    fetch_pc_unit #(.RESET_PC(32'h100)) dut (
        .clk(clk), .reset(reset),
        .INT_BASE(INT_BASE), .EXC_BASE(EXC_BASE),
        .insTarget(insTarget), .insResult(insResult),
        .intCode(intCode), .excCode(excCode),
        .selectInt(selectInt), .selectExc(selectExc),
        .selectTarget(selectTarget), .selectResult(selectResult),
        .start(start), .halt(halt), .fetchReady(fetchReady),
        .pcOut(pcOut), .pcValid(pcValid), .pcSize(pcSize), .pcTag(pcTag),
        .savedIP(savedIP), .running(running), .dbgState(dbgState)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_size(input logic [31:0] pc);
        return 8'((16 - int'(pc % 16)) / 4);
    endfunction

    task automatic model_reset();
        mMode = 0; mPc = 32'h100; mSaved = 0; mTag = 0;
    endtask

    task automatic model_step();
        logic [31:0] a;
        if (selectInt || selectExc || selectTarget || selectResult) begin
            if (selectInt)        a = (INT_BASE & ~32'h3FF) | (32'(intCode) * 4);
            else if (selectExc)   a = (EXC_BASE & ~32'h3FF) | (32'(excCode) * 4);
            else if (selectTarget) a = insTarget & ~32'h3;
            else                  a = insResult & ~32'h3;
            if (selectInt || selectExc) mSaved = mPc;
            mPc   = a;
            mTag  = (mTag + 1) % 8;
            mMode = 1;
        end else begin
            if (mMode == 1 && fetchReady) mPc = 32'((64'(mPc) / 16 + 1) * 16);
            if (halt) begin
                if (mMode == 1) mMode = 2;
            end else if (start) begin
                mMode = 1;
            end
        end
    endtask

    task automatic clear_inputs();
        INT_BASE = 0; EXC_BASE = 0; insTarget = 0; insResult = 0;
        intCode = 0; excCode = 0;
        selectInt = 0; selectExc = 0; selectTarget = 0; selectResult = 0;
        start = 0; halt = 0; fetchReady = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        #2 reset = 1'b1;
        model_reset();
        #1;
        total++; if (pcOut !== 32'h100) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pcOut, 32'h100); end
        total++; if (pcValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", pcValid); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b exp=0", running); end
        total++; if (pcTag !== 3'd0) begin bad++; $display("FAIL reset_tag got=%0d exp=0", pcTag); end
        total++; if (savedIP !== 32'h0) begin bad++; $display("FAIL reset_saved got=%h exp=0", savedIP); end
        total++; if (pcSize !== 8'd4) begin bad++; $display("FAIL reset_size got=%0d exp=4", pcSize); end
        @(negedge clk); reset = 1'b0;
        fetchReady = 1'b1;
        tick(); tick();
        total++; if (pcOut !== 32'h100 || pcValid !== 1'b0) begin
            bad++; $display("FAIL idle_hold pc=%h valid=%b exp pc=100 valid=0", pcOut, pcValid);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        start = 1'b1; fetchReady = 1'b1;
        tick();
        start = 1'b0;
        exp_pc = 32'h100;
        for (int i = 0; i < 4; i++) begin
            total++; if (pcOut !== exp_pc || pcOut !== mPc) begin
                bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pcOut, exp_pc);
            end
            total++; if (pcSize !== 8'd4 || pcTag !== 3'd0 || pcValid !== 1'b1) begin
                bad++; $display("FAIL seq_attr[%0d] size=%0d tag=%0d valid=%b exp 4/0/1", i, pcSize, pcTag, pcValid);
            end
            if (i < 3) tick();
            exp_pc = exp_pc + 32'h10;
        end
    endtask

    task automatic test_redirect();
        selectTarget = 1'b1; insTarget = 32'h20E;
        tick();
        selectTarget = 1'b0;
        total++; if (pcOut !== 32'h20C || pcSize !== 8'd1 || pcTag !== 3'd1) begin
            bad++; $display("FAIL target pc=%h size=%0d tag=%0d exp 20c/1/1", pcOut, pcSize, pcTag);
        end
        tick();
        total++; if (pcOut !== 32'h210 || pcSize !== 8'd4) begin
            bad++; $display("FAIL target_next pc=%h size=%0d exp 210/4", pcOut, pcSize);
        end
        selectResult = 1'b1; insResult = 32'h131;
        tick();
        selectResult = 1'b0;
        total++; if (pcOut !== 32'h130) begin bad++; $display("FAIL result_align got=%h exp=130", pcOut); end
        selectInt = 1'b1; selectTarget = 1'b1; insTarget = 32'h5000;
        INT_BASE = 32'hFFFF0000; intCode = 8'h05;
        tick();
        selectInt = 1'b0; selectTarget = 1'b0;
        total++; if (pcOut !== 32'hFFFF0014 || savedIP !== 32'h130) begin
            bad++; $display("FAIL int_prio pc=%h saved=%h exp ffff0014/130", pcOut, savedIP);
        end
        total++; if (pcTag !== 3'd3) begin bad++; $display("FAIL int_tag got=%0d exp=3", pcTag); end
        selectExc = 1'b1; selectResult = 1'b1; EXC_BASE = 32'h8000_0000; excCode = 8'hFF;
        tick();
        selectExc = 1'b0; selectResult = 1'b0;
        total++; if (pcOut !== 32'h8000_03FC || savedIP !== 32'hFFFF0014) begin
            bad++; $display("FAIL exc_prio pc=%h saved=%h exp 800003fc/ffff0014", pcOut, savedIP);
        end
    endtask

    task automatic test_stall_wrap();
        selectTarget = 1'b1; insTarget = 32'hFFFFFFF0;
        tick();
        selectTarget = 1'b0; fetchReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (pcOut !== 32'hFFFFFFF0 || pcTag !== 3'(mTag) || pcValid !== 1'b1) begin
                bad++; $display("FAIL stall[%0d] pc=%h tag=%0d exp fffffff0/%0d", i, pcOut, pcTag, mTag);
            end
        end
        fetchReady = 1'b1;
        tick();
        total++; if (pcOut !== 32'h0) begin bad++; $display("FAIL wrap got=%h exp=0", pcOut); end
    endtask

    task automatic test_halt_resume();
        halt = 1'b1;
        tick();
        total++; if (pcValid !== 1'b0 || running !== 1'b0) begin
            bad++; $display("FAIL halt valid=%b running=%b exp 0/0", pcValid, running);
        end
        start = 1'b1;
        tick();
        total++; if (pcValid !== 1'b0) begin bad++; $display("FAIL halt_beats_start valid=%b exp=0", pcValid); end
        start = 1'b0;
        selectResult = 1'b1; insResult = 32'h400;
        tick();
        selectResult = 1'b0; halt = 1'b0;
        total++; if (pcOut !== 32'h400 || pcValid !== 1'b1) begin
            bad++; $display("FAIL result_resume pc=%h valid=%b exp 400/1", pcOut, pcValid);
        end
        fetchReady = 1'b0;
        tick(); tick();
        #2 reset = 1'b1;
        model_reset();
        #1;
        total++; if (pcOut !== 32'h100 || pcValid !== 1'b0 || pcTag !== 3'd0 || savedIP !== 32'h0 || running !== 1'b0) begin
            bad++; $display("FAIL reset_mid_stall pc=%h valid=%b tag=%0d saved=%h run=%b", pcOut, pcValid, pcTag, savedIP, running);
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_tag_wrap();
        for (int i = 1; i <= 8; i++) begin
            selectResult = 1'b1; insResult = 32'($urandom);
            tick();
            total++; if (pcTag !== 3'(i % 8)) begin
                bad++; $display("FAIL tag_wrap[%0d] got=%0d exp=%0d", i, pcTag, i % 8);
            end
        end
        selectResult = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            INT_BASE = $urandom; EXC_BASE = $urandom;
            insTarget = $urandom; insResult = $urandom;
            intCode = 8'($urandom); excCode = 8'($urandom);
            selectInt    = ($urandom_range(0, 15) == 0);
            selectExc    = ($urandom_range(0, 15) == 0);
            selectTarget = ($urandom_range(0, 7) == 0);
            selectResult = ($urandom_range(0, 7) == 0);
            start = ($urandom_range(0, 3) == 0);
            halt  = ($urandom_range(0, 7) == 0);
            fetchReady = ($urandom_range(0, 3) != 0);
            tick();
            total++; if (pcOut !== mPc || pcTag !== 3'(mTag) || savedIP !== mSaved) begin
                bad++; $display("FAIL rnd_regs[%0d] pc=%h/%h tag=%0d/%0d saved=%h/%h", i, pcOut, mPc, pcTag, mTag, savedIP, mSaved);
            end
            total++; if (pcValid !== (mMode == 1) || running !== (mMode == 1) || pcSize !== model_size(mPc)) begin
                bad++; $display("FAIL rnd_ctrl[%0d] valid=%b run=%b size=%0d exp mode=%0d size=%0d", i, pcValid, running, pcSize, mMode, model_size(mPc));
            end
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        model_reset();
        test_reset();
        test_sequential();
        test_redirect();
        test_stall_wrap();
        test_halt_resume();
        test_tag_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
